// File: rtl/decode_sequencer_if.sv
// Request/strobe bundle for decode_sequencer.
// DECODE_SEQUENCER_DIR_EN adds the dir_i direction bit.
interface decode_sequencer_if #(
  parameter int unsigned OUTPUT_WIDTH = 6,
  parameter int unsigned LEN_WIDTH    = 8
);
  localparam int unsigned IW = $clog2(OUTPUT_WIDTH > 2 ? OUTPUT_WIDTH : 2);

  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [IW-1:0]           req_start_i;
  logic [LEN_WIDTH-1:0]    req_len_i;
  logic                    hold_i;
`ifdef DECODE_SEQUENCER_DIR_EN
  logic                    dir_i;
`endif
  logic [OUTPUT_WIDTH-1:0] strobe_o;
  logic [IW-1:0]           index_o;
  logic                    busy_o;
  logic                    done_o;

  modport master (
`ifdef DECODE_SEQUENCER_DIR_EN
    output dir_i,
`endif
    output req_valid_i, req_start_i, req_len_i, hold_i,
    input  req_ready_o, strobe_o, index_o, busy_o, done_o
  );

  modport slave (
`ifdef DECODE_SEQUENCER_DIR_EN
    input  dir_i,
`endif
    input  req_valid_i, req_start_i, req_len_i, hold_i,
    output req_ready_o, strobe_o, index_o, busy_o, done_o
  );
endinterface

// File: rtl/decode_sequencer.sv
// Burst sequencer stepping a wrapping index through a tree decoder, one strobe per advancing cycle.
// Optional feature macro: DECODE_SEQUENCER_DIR_EN (adds down-counting via dir_i).
module decode_sequencer #(
  parameter int unsigned OUTPUT_WIDTH = 6,
  parameter int unsigned LEN_WIDTH    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  decode_sequencer_if.slave bus
);
  localparam int unsigned IW    = $clog2(OUTPUT_WIDTH > 2 ? OUTPUT_WIDTH : 2);
  localparam int unsigned NODES = 2 ** (IW + 1);
  localparam int unsigned LEAF0 = 2 ** IW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        index_q, index_nxt, start_eff;
  logic [LEN_WIDTH-1:0] remaining_q;
  logic                 accept, advance;
  logic [NODES-1:1]     node;
  logic [OUTPUT_WIDTH-1:0] strobe_c;

  assign accept  = (state_q == IDLE) && bus.req_valid_i;
  assign advance = (state_q == RUN) && !bus.hold_i;

  // Indices past the last output are treated as a request for output 0.
  assign start_eff = (32'(bus.req_start_i) >= OUTPUT_WIDTH) ? IW'(0) : bus.req_start_i;

`ifdef DECODE_SEQUENCER_DIR_EN
  logic dir_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       dir_q <= 1'b0;
    else if (accept) dir_q <= bus.dir_i;
  end

  always_comb begin
    index_nxt = index_q;
    if (dir_q)
      index_nxt = (index_q == IW'(0)) ? IW'(OUTPUT_WIDTH - 1) : index_q - IW'(1);
    else
      index_nxt = (index_q == IW'(OUTPUT_WIDTH - 1)) ? IW'(0) : index_q + IW'(1);
  end
`else
  always_comb begin
    index_nxt = (index_q == IW'(OUTPUT_WIDTH - 1)) ? IW'(0) : index_q + IW'(1);
  end
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (bus.req_len_i == '0) ? DONE : RUN;
      RUN:  if (advance && remaining_q == LEN_WIDTH'(1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Index and remaining-count datapath.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      index_q     <= '0;
      remaining_q <= '0;
    end else if (accept) begin
      index_q     <= start_eff;
      remaining_q <= bus.req_len_i;
    end else if (advance) begin
      index_q     <= index_nxt;
      remaining_q <= remaining_q - LEN_WIDTH'(1);
    end
  end

  // Binary enable tree: each level splits on one index bit, MSB first; leaves are the strobes.
  assign node[1] = advance;
  for (genvar d = 0; d < IW; d++) begin : g_lvl
    for (genvar k = 0; k < 2 ** d; k++) begin : g_node
      localparam int unsigned N = 2 ** d + k;
      assign node[2*N]   = node[N] & ~index_q[IW-1-d];
      assign node[2*N+1] = node[N] &  index_q[IW-1-d];
    end
  end

  assign strobe_c = node[LEAF0+OUTPUT_WIDTH-1:LEAF0];

  if (OUTPUT_WIDTH < LEAF0) begin : g_pad
    logic unused_leaves;
    assign unused_leaves = ^node[NODES-1:LEAF0+OUTPUT_WIDTH];
  end

  // Outputs decoded from registered state.
  always_comb begin
    bus.req_ready_o = 1'b0;
    bus.busy_o      = 1'b0;
    bus.done_o      = 1'b0;
    bus.index_o     = index_q;
    bus.strobe_o    = strobe_c;
    case (state_q)
      IDLE:    bus.req_ready_o = 1'b1;
      RUN:     bus.busy_o      = 1'b1;
      DONE:    bus.done_o      = 1'b1;
      default: bus.req_ready_o = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_decode_sequencer.sv
// Self-checking bench for decode_sequencer: directed vector table, reset sequences, random bursts.
module tb_decode_sequencer;
  localparam int unsigned W  = 6;
  localparam int unsigned LW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  decode_sequencer_if #(.OUTPUT_WIDTH(W), .LEN_WIDTH(LW)) bus ();

  decode_sequencer #(.OUTPUT_WIDTH(W), .LEN_WIDTH(LW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    int          start;
    int          len;
    logic [31:0] mask;
    bit          dn;
    int          first_s;
    int          last_s;
    int          done_c;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Position of the k-th strobe of a burst starting at s.
  function automatic int wrap_idx(input int s, input int k, input bit dn);
    if (dn) return (s - (k % W) + W) % W;
    return (s + k) % W;
  endfunction

  task automatic drive_dir(input bit dn);
`ifdef DECODE_SEQUENCER_DIR_EN
    bus.dir_i = dn;
`else
    if (dn) $display("note: dir request ignored without dir support");
`endif
  endtask

  // Issues one burst and checks every cycle against the strobe-list model.
  task automatic run_burst(input int start, input int len, input logic [31:0] mask,
                           input int hold_pct, input bit dn,
                           output int first_s, output int last_s, output int done_c);
    int s_eff;
    int q[$];
    int c;
    bit h;
    s_eff   = (start >= W) ? 0 : start;
    first_s = 0;
    last_s  = 0;
    done_c  = -1;
    for (int k = 0; k < len; k++) q.push_back(wrap_idx(s_eff, k, dn));

    @(posedge clk); #1;
    bus.req_valid_i = 1'b1;
    bus.req_start_i = 3'(start);
    bus.req_len_i   = 8'(len);
    bus.hold_i      = 1'($urandom_range(1));
    drive_dir(dn);
    @(negedge clk);
    check("idle ready", 32'(bus.req_ready_o), 1);
    check("idle busy", 32'(bus.busy_o), 0);
    check("idle strobe", 32'(bus.strobe_o), 0);

    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.req_start_i = 3'($urandom);
    bus.req_len_i   = 8'($urandom);
    drive_dir(1'($urandom_range(1)) & dn);
    c = 1;
    while (done_c < 0 && c <= 4 * len + 64) begin
      h = (c < 32 && mask[c]) || (int'($urandom_range(99)) < hold_pct);
      bus.hold_i = h;
      @(negedge clk);
      if (q.size() > 0) begin
        check("run busy", 32'(bus.busy_o), 1);
        check("run done", 32'(bus.done_o), 0);
        check("run index", 32'(bus.index_o), q[0]);
        check("run strobe", 32'(bus.strobe_o), h ? 0 : (1 << q[0]));
        if (!h) begin
          if (first_s == 0) first_s = 1 << q[0];
          last_s = 1 << q[0];
          void'(q.pop_front());
        end
      end else begin
        check("done pulse", 32'(bus.done_o), 1);
        check("done ready", 32'(bus.req_ready_o), 0);
        check("done busy", 32'(bus.busy_o), 0);
        check("done strobe", 32'(bus.strobe_o), 0);
        check("done index", 32'(bus.index_o), wrap_idx(s_eff, len, dn));
        done_c = c;
      end
      if (done_c < 0) begin
        @(posedge clk); #1;
        c++;
      end
    end
    if (done_c < 0) check("burst timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs, ls, dc;
    bit dn;
    int ln;

    vecs.push_back('{4, 4, 32'h0,  1'b0, 'h10, 'h02, 5});
    vecs.push_back('{1, 3, 32'h4,  1'b0, 'h02, 'h08, 5});
    vecs.push_back('{3, 0, 32'h0,  1'b0, 0,    0,    1});
    vecs.push_back('{5, 2, 32'h0,  1'b0, 'h20, 'h01, 3});
    vecs.push_back('{7, 2, 32'h0,  1'b0, 'h01, 'h02, 3});
    vecs.push_back('{2, 6, 32'h82, 1'b0, 'h04, 'h02, 9});
    vecs.push_back('{0, 1, 32'h0,  1'b0, 'h01, 'h01, 2});
`ifdef DECODE_SEQUENCER_DIR_EN
    vecs.push_back('{1, 3, 32'h0,  1'b1, 'h02, 'h20, 4});
    vecs.push_back('{7, 2, 32'h0,  1'b1, 'h01, 'h20, 3});
`endif

    bus.req_valid_i = 1'b0;
    bus.req_start_i = '0;
    bus.req_len_i   = '0;
    bus.hold_i      = 1'b0;
    drive_dir(1'b0);

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst strobe", 32'(bus.strobe_o), 0);
    check("rst ready", 32'(bus.req_ready_o), 1);
    check("rst busy", 32'(bus.busy_o), 0);
    check("rst done", 32'(bus.done_o), 0);
    check("rst index", 32'(bus.index_o), 0);
    @(posedge clk); #1 rst = 1'b0;

    foreach (vecs[i]) begin
      run_burst(vecs[i].start, vecs[i].len, vecs[i].mask, 0, vecs[i].dn, fs, ls, dc);
      check($sformatf("vec%0d first", i), fs, vecs[i].first_s);
      check($sformatf("vec%0d last", i), ls, vecs[i].last_s);
      check($sformatf("vec%0d done_cycle", i), dc, vecs[i].done_c);
    end

    // Reset mid-burst: start=0 len=5, reset during the second strobe cycle.
    @(posedge clk); #1;
    bus.hold_i      = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_start_i = 3'd0;
    bus.req_len_i   = 8'd5;
    drive_dir(1'b0);
    @(posedge clk); #1 bus.req_valid_i = 1'b0;
    @(posedge clk); #1;
    check("midrst pre strobe", 32'(bus.strobe_o), 'h02);
    #2 rst = 1'b1;
    #1;
    check("midrst strobe", 32'(bus.strobe_o), 0);
    check("midrst ready", 32'(bus.req_ready_o), 1);
    check("midrst busy", 32'(bus.busy_o), 0);
    check("midrst index", 32'(bus.index_o), 0);
    @(posedge clk); #1 rst = 1'b0;
    run_burst(2, 1, 32'h0, 0, 1'b0, fs, ls, dc);
    check("postrst strobe", fs, 'h04);
    check("postrst done_cycle", dc, 2);

    // Random bursts, back-to-back, with random stalls.
    for (int n = 0; n < 40; n++) begin
`ifdef DECODE_SEQUENCER_DIR_EN
      dn = 1'($urandom_range(1));
`else
      dn = 1'b0;
`endif
      ln = ($urandom_range(9) == 0) ? int'($urandom_range(255)) : int'($urandom_range(20));
      run_burst(int'($urandom_range(7)), ln, $urandom, int'($urandom_range(40)), dn, fs, ls, dc);
    end

    @(posedge clk); #1 bus.hold_i = 1'b0;
    @(negedge clk);
    check("final ready", 32'(bus.req_ready_o), 1);
    check("final done", 32'(bus.done_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
